// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - stall/flush/bubble sequencer for a 5-stage pipeline with a data-memory wait watchdog
//
// Purpose:
//   Produces the pipeline register controls for load-use stalls, taken branches
//   and multi-cycle data-memory accesses. A memory access that is not
//   acknowledged within TIMEOUT wait cycles parks the pipeline in HALT until
//   reset.
//
// Parameters:
//   TIMEOUT       maximum dmem wait cycles before halt (2..255)
//
// Ports:
//   clk           single clock, rising edge
//   rst           synchronous active-high reset
//   hz_stall      load-use hazard request
//   branch_taken  beq resolved taken in ID
//   dmem_req      MEM-stage lw/sw access active
//   dmem_ack      data memory completes the access this cycle
//   pc_we         PC write enable
//   ifid_we       IF/ID write enable
//   ifid_flush    IF/ID contents replaced by NOP
//   idex_bubble   ID/EX control fields zeroed
//   exmem_we      ID/EX and EX/MEM write enable
//   memwb_bubble  MEM/WB control fields zeroed
//   halted        memory-timeout indication (held until reset)
//   state         current state encoding
//   stall_cycles  (PIPE_SEQ_STALL_CNT_EN only) saturating count of cycles with pc_we=0
//
// Configuration macro: PIPE_SEQ_STALL_CNT_EN adds the stall_cycles counter.

module pipeline_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hz_stall,
  input  logic        branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        exmem_we,
  output logic        memwb_bubble,
  output logic        halted,
  output logic [1:0]  state
`ifdef PIPE_SEQ_STALL_CNT_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10,
    ILLEGAL  = 2'b11
  } seq_state_t;

  // Counter value on which an unacknowledged MEM_WAIT cycle gives up.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  seq_state_t cur_state;
  seq_state_t nxt_state;
  logic [7:0] wait_cnt;
  logic [7:0] nxt_cnt;
  logic       mem_pending;

  assign mem_pending = dmem_req && !dmem_ack;
  assign state       = cur_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= RUN;
      wait_cnt  <= 8'd0;
    end else begin
      cur_state <= nxt_state;
      wait_cnt  <= nxt_cnt;
    end
  end

  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_we     = 1'b1;
    memwb_bubble = 1'b0;
    halted       = 1'b0;
    nxt_state    = RUN;
    nxt_cnt      = 8'd0;

    case (cur_state)
      HALT: begin
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        exmem_we     = 1'b0;
        memwb_bubble = 1'b1;
        halted       = 1'b1;
        nxt_state    = HALT;
        nxt_cnt      = wait_cnt;
      end

      RUN, MEM_WAIT: begin
        if (mem_pending) begin
          // Freeze everything up to MEM and drain a bubble into WB; hazard
          // and branch requests are irrelevant while the access is pending.
          pc_we        = 1'b0;
          ifid_we      = 1'b0;
          exmem_we     = 1'b0;
          memwb_bubble = 1'b1;
          if (cur_state == RUN) begin
            nxt_state = MEM_WAIT;
            nxt_cnt   = 8'd1;
          end else begin
            nxt_cnt   = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
            nxt_state = (wait_cnt == LAST_WAIT) ? HALT : MEM_WAIT;
          end
        end else if (hz_stall) begin
          // Load-use stall wins over a branch flush: the instruction in
          // IF/ID must be kept, not discarded.
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
        end else if (branch_taken) begin
          ifid_flush = 1'b1;
        end
      end

      default: begin
        // Unreachable encoding: recover to RUN with plain normal outputs.
        nxt_state = RUN;
      end
    endcase
  end

`ifdef PIPE_SEQ_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 16'd0;
    end else if (!pc_we && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule
